// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the M stage and its neighbours.
// Holds the XM/MW bundle layouts, IF feedback, data-memory depth and counter width.
// Pure type/constant package: no logic, no latency, no flow control.
package mem_stage_pkg;

    // log2 of data-memory depth in 32-bit words
    localparam int MemAddrWidth = 4;
    // width of the saturating load/store counters
    localparam int CntWidth     = 16;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef logic [31:0] Register;
    typedef logic [31:0] ProgramCounter;
    typedef logic [4:0]  RegIdx;

    // Controls consumed in the M stage itself
    typedef struct packed {
        logic read_mem;
        logic write_mem;
        logic fpu_to_mem;   // address/store data come from the FPU side
        logic branch;
        logic jmp;
    } M_ctrl;

    // Controls carried through to write-back
    typedef struct packed {
        logic reg_write;
        logic fp_reg_write;
        logic mem_to_reg;
        logic fpu_to_wb;    // M-stage result comes from the FPU side
    } MW_ctrl;

    typedef struct packed {
        M_ctrl  m;
        MW_ctrl mw;
    } XM_ctrl;

    typedef struct packed {
        Register       alu_addr;
        Register       fpu_addr;
        Register       alu_val;
        Register       fpu_val;
        RegIdx         dst;
        logic          alu_zero;
        ProgramCounter pc_branch;
    } XM_data;

    typedef struct packed {
        Register mem;
        Register alu;
        RegIdx   dst;
    } WB_input;

    typedef struct packed {
        logic          branch;
        logic          alu_zero;
        logic          jmp;
        ProgramCounter pc_branch;
        ProgramCounter pc_jmp;
        logic          stall;
    } IF_input;

    typedef struct packed {
        logic [CntWidth-1:0] ld_count;
        logic [CntWidth-1:0] st_count;
    } M_stats;

    function automatic logic is_word_aligned(input Register addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: one synchronous write port, one combinational read port.
// Latency: write lands at the rising edge; read is same-cycle and returns the pre-write word.
// No backpressure: the caller qualifies i_wr_en; reset clears every word asynchronously.
// Ports: clk, rst_n; i_wr_en/i_wr_idx/i_wr_dat write port; i_rd_idx -> o_rd_dat read port.
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int MemAddrWidth = mem_stage_pkg::MemAddrWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [MemAddrWidth-1:0] i_wr_idx,
    input  Register                 i_wr_dat,
    input  logic [MemAddrWidth-1:0] i_rd_idx,
    output Register                 o_rd_dat
);

    localparam int Depth = 1 << MemAddrWidth;

    Register r_mem [Depth];

    // Flop array rather than a RAM macro so reset can clear every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/mem_stage.sv
// M stage: selects address/data, performs loads/stores on data_mem, owns the MW register.
// Latency: loads and results reach wb_out one cycle later; fwd_val and if_ctrl are combinational.
// Backpressure: stall holds MW and blocks the write; flush (higher priority) bubbles MW.
// Ports: clk, rst_n; xm_ctrl/xm_data/pc_jmp in; stall/flush in; mw_ctrl/wb_out registered out;
//        fwd_val/if_ctrl combinational out; misalign_err sticky; ld_count/st_count saturating.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MemAddrWidth = mem_stage_pkg::MemAddrWidth,
    parameter int CntWidth     = mem_stage_pkg::CntWidth
) (
    input  logic                clk,
    input  logic                rst_n,
    input  XM_ctrl              xm_ctrl,
    input  XM_data              xm_data,
    input  ProgramCounter       pc_jmp,
    input  logic                stall,
    input  logic                flush,
    output MW_ctrl              mw_ctrl,
    output WB_input             wb_out,
    output Register             fwd_val,
    output IF_input             if_ctrl,
    output logic                misalign_err,
    output logic [CntWidth-1:0] ld_count,
    output logic [CntWidth-1:0] st_count
);

    Register                 w_addr;
    Register                 w_sdata;
    Register                 w_res;
    Register                 w_mem_rdata;
    Register                 w_rdata;
    logic [MemAddrWidth-1:0] w_index;
    logic                    w_aligned;
    logic                    w_live;
    logic                    w_ld_evt;
    logic                    w_st_evt;
    logic                    w_misalign_evt;
    logic                    w_unused;

    MW_ctrl                  r_mw_ctrl;
    WB_input                 r_wb;
    logic                    r_misalign_err;
    logic [CntWidth-1:0]     r_ld_count;
    logic [CntWidth-1:0]     r_st_count;

    // ---------------- source selection ----------------
    assign w_addr  = xm_ctrl.m.fpu_to_mem ? xm_data.fpu_addr : xm_data.alu_addr;
    assign w_sdata = xm_ctrl.m.fpu_to_mem ? xm_data.fpu_val  : xm_data.alu_val;
    assign w_res   = xm_ctrl.mw.fpu_to_wb ? xm_data.fpu_addr : xm_data.alu_addr;

    // Upper address bits are dropped: the memory aliases across the 32-bit space.
    assign w_index   = w_addr[MemAddrWidth+1:2];
    assign w_aligned = is_word_aligned(w_addr);
    assign w_unused  = ^w_addr[31:MemAddrWidth+2];

    assign w_live         = ~stall & ~flush;
    assign w_ld_evt       = w_live & xm_ctrl.m.read_mem  & w_aligned;
    assign w_st_evt       = w_live & xm_ctrl.m.write_mem & w_aligned;
    assign w_misalign_evt = w_live & (xm_ctrl.m.read_mem | xm_ctrl.m.write_mem) & ~w_aligned;

    // ---------------- data memory ----------------
    data_mem #(
        .MemAddrWidth (MemAddrWidth)
    ) u_data_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (w_st_evt),
        .i_wr_idx (w_index),
        .i_wr_dat (w_sdata),
        .i_rd_idx (w_index),
        .o_rd_dat (w_mem_rdata)
    );

    // A misaligned load returns zero instead of a shifted/partial word.
    assign w_rdata = (xm_ctrl.m.read_mem & w_aligned) ? w_mem_rdata : '0;

    // ---------------- MW pipeline register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mw_ctrl <= '0;
            r_wb      <= '0;
        end else if (flush) begin
            r_mw_ctrl <= '0;
            r_wb      <= '0;
        end else if (!stall) begin
            r_mw_ctrl  <= xm_ctrl.mw;
            r_wb.mem   <= w_rdata;
            r_wb.alu   <= w_res;
            r_wb.dst   <= xm_data.dst;
        end
    end

    // ---------------- sticky error and statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
            r_ld_count     <= '0;
            r_st_count     <= '0;
        end else begin
            if (w_misalign_evt) begin
                r_misalign_err <= 1'b1;
            end
            // Counters stop at all-ones so a long run never reads as a small count.
            if (w_ld_evt && (r_ld_count != '1)) begin
                r_ld_count <= r_ld_count + 1'b1;
            end
            if (w_st_evt && (r_st_count != '1)) begin
                r_st_count <= r_st_count + 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign mw_ctrl      = r_mw_ctrl;
    assign wb_out       = r_wb;
    assign fwd_val      = w_res;
    assign misalign_err = r_misalign_err;
    assign ld_count     = r_ld_count;
    assign st_count     = r_st_count;

    // Fetch qualifies these itself, so they are passed through ungated.
    assign if_ctrl.branch    = xm_ctrl.m.branch;
    assign if_ctrl.alu_zero  = xm_data.alu_zero;
    assign if_ctrl.jmp       = xm_ctrl.m.jmp;
    assign if_ctrl.pc_branch = xm_data.pc_branch;
    assign if_ctrl.pc_jmp    = pc_jmp;
    assign if_ctrl.stall     = DISABLE;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk;
    logic          rst_n;
    XM_ctrl        xm_ctrl;
    XM_data        xm_data;
    ProgramCounter pc_jmp;
    logic          stall;
    logic          flush;
    MW_ctrl        mw_ctrl;
    WB_input       wb_out;
    Register       fwd_val;
    IF_input       if_ctrl;
    logic          misalign_err;
    logic [15:0]   ld_count;
    logic [15:0]   st_count;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .xm_ctrl      (xm_ctrl),
        .xm_data      (xm_data),
        .pc_jmp       (pc_jmp),
        .stall        (stall),
        .flush        (flush),
        .mw_ctrl      (mw_ctrl),
        .wb_out       (wb_out),
        .fwd_val      (fwd_val),
        .if_ctrl      (if_ctrl),
        .misalign_err (misalign_err),
        .ld_count     (ld_count),
        .st_count     (st_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam MW_ctrl MWC_LD = '{reg_write: 1'b1, fp_reg_write: 1'b0, mem_to_reg: 1'b1, fpu_to_wb: 1'b0};
    localparam MW_ctrl MWC_0  = '0;

    typedef struct {
        logic    rd;
        logic    wr;
        Register addr;
        Register val;
        logic    st;
        logic    fl;
        MW_ctrl  e_mwc;
        Register e_mem;
        Register e_alu;
        RegIdx   e_dst;
        logic    e_err;
        int      e_ld;
        int      e_st;
    } vec_t;

    vec_t tbl[14];

    // Behavioural reference state
    Register ref_mem [16];
    MW_ctrl  ref_mwc;
    WB_input ref_wb;
    logic    ref_err;
    int      ref_ld;
    int      ref_st;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input Register addr, input Register val,
                         input logic st, input logic fl, input RegIdx dst);
        xm_ctrl            = '0;
        xm_data            = '0;
        xm_ctrl.m.read_mem  = rd;
        xm_ctrl.m.write_mem = wr;
        xm_ctrl.mw          = rd ? MWC_LD : MWC_0;
        xm_data.alu_addr    = addr;
        xm_data.alu_val     = val;
        xm_data.dst         = dst;
        stall               = st;
        flush               = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mwc = '0;
        ref_wb  = '0;
        ref_err = 1'b0;
        ref_ld  = 0;
        ref_st  = 0;
    endtask

    function automatic vec_t mkv(logic rd, logic wr, Register addr, Register val, logic st, logic fl,
                                 MW_ctrl e_mwc, Register e_mem, Register e_alu, RegIdx e_dst,
                                 logic e_err, int e_ld, int e_st);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.val = val; v.st = st; v.fl = fl;
        v.e_mwc = e_mwc; v.e_mem = e_mem; v.e_alu = e_alu; v.e_dst = e_dst;
        v.e_err = e_err; v.e_ld = e_ld; v.e_st = e_st;
        return v;
    endfunction

    // Reference model: one clock edge, computed from the stage's rules with plain arithmetic.
    task automatic model_edge();
        logic    rd, wr, live, aligned;
        Register addr, sdata, res, rdata;
        int      idx;
        rd      = xm_ctrl.m.read_mem;
        wr      = xm_ctrl.m.write_mem;
        addr    = xm_ctrl.m.fpu_to_mem ? xm_data.fpu_addr : xm_data.alu_addr;
        sdata   = xm_ctrl.m.fpu_to_mem ? xm_data.fpu_val  : xm_data.alu_val;
        res     = xm_ctrl.mw.fpu_to_wb ? xm_data.fpu_addr : xm_data.alu_addr;
        live    = !stall && !flush;
        aligned = (addr % 4) == 0;
        idx     = int'((addr / 4) % 16);
        rdata   = (rd && aligned) ? ref_mem[idx] : 32'h0;
        if (flush) begin
            ref_mwc = '0;
            ref_wb  = '0;
        end else if (!stall) begin
            ref_mwc = xm_ctrl.mw;
            ref_wb  = '{mem: rdata, alu: res, dst: xm_data.dst};
        end
        if (live && wr && aligned) ref_mem[idx] = sdata;
        if (live && (rd || wr) && !aligned) ref_err = 1'b1;
        if (live && rd && aligned && ref_ld < 65535) ref_ld++;
        if (live && wr && aligned && ref_st < 65535) ref_st++;
    endtask

    initial begin
        rst_n  = 1'b0;
        pc_jmp = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        #2;

        // ---------------- reset state ----------------
        chk("rst_mw_ctrl", mw_ctrl, 0);
        chk("rst_wb_out",  wb_out, 0);
        chk("rst_err",     misalign_err, 0);
        chk("rst_ld",      ld_count, 0);
        chk("rst_st",      st_count, 0);
        do_reset();

        // ---------------- directed table ----------------
        tbl[0]  = mkv(1,0,32'h0000_0008,32'h0,          0,0, MWC_LD,32'h0,        32'h08,5'd1,0,0,0);
        tbl[0]  = mkv(0,1,32'h0000_0008,32'hDEAD_BEEF,  0,0, MWC_0, 32'h0,        32'h08,5'd1,0,0,1);
        tbl[1]  = mkv(1,0,32'h0000_0008,32'h0,          0,0, MWC_LD,32'hDEAD_BEEF,32'h08,5'd2,0,1,1);
        tbl[2]  = mkv(0,1,32'h0000_0048,32'h1234_5678,  0,0, MWC_0, 32'h0,        32'h48,5'd3,0,1,2);
        tbl[3]  = mkv(1,0,32'h0000_0008,32'h0,          0,0, MWC_LD,32'h1234_5678,32'h08,5'd4,0,2,2);
        tbl[4]  = mkv(0,1,32'h0000_0006,32'h0000_0BAD,  0,0, MWC_0, 32'h0,        32'h06,5'd5,1,2,2);
        tbl[5]  = mkv(1,0,32'h0000_0004,32'h0,          0,0, MWC_LD,32'h0,        32'h04,5'd6,1,3,2);
        tbl[6]  = mkv(1,0,32'h0000_0008,32'h0,          0,0, MWC_LD,32'h1234_5678,32'h08,5'd7,1,4,2);
        tbl[7]  = mkv(0,1,32'h0000_0008,32'h0000_AAAA,  1,0, MWC_LD,32'h1234_5678,32'h08,5'd7,1,4,2);
        tbl[8]  = mkv(0,1,32'h0000_0008,32'h0000_BBBB,  1,1, MWC_0, 32'h0,        32'h00,5'd0,1,4,2);
        tbl[9]  = mkv(1,0,32'h0000_0008,32'h0,          0,0, MWC_LD,32'h1234_5678,32'h08,5'd10,1,5,2);
        tbl[10] = mkv(1,0,32'h0000_0009,32'h0,          0,0, MWC_LD,32'h0,        32'h09,5'd11,1,5,2);
        tbl[11] = mkv(1,0,32'h0000_0008,32'h0,          1,0, MWC_LD,32'h0,        32'h09,5'd11,1,5,2);
        tbl[12] = mkv(1,0,32'h0000_0008,32'h0,          0,1, MWC_0, 32'h0,        32'h00,5'd0,1,5,2);
        tbl[13] = mkv(1,0,32'h0000_0048,32'h0,          0,0, MWC_LD,32'h1234_5678,32'h48,5'd14,1,6,2);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].val, tbl[i].st, tbl[i].fl, RegIdx'(i + 1));
            step();
            chk($sformatf("v%0d_mw_ctrl", i), mw_ctrl,      tbl[i].e_mwc);
            chk($sformatf("v%0d_mem", i),     wb_out.mem,   tbl[i].e_mem);
            chk($sformatf("v%0d_alu", i),     wb_out.alu,   tbl[i].e_alu);
            chk($sformatf("v%0d_dst", i),     wb_out.dst,   tbl[i].e_dst);
            chk($sformatf("v%0d_err", i),     misalign_err, tbl[i].e_err);
            chk($sformatf("v%0d_ld", i),      ld_count,     tbl[i].e_ld);
            chk($sformatf("v%0d_st", i),      st_count,     tbl[i].e_st);
        end

        // misalign_err is sticky through clean cycles, cleared only by reset
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 5'd0);
            step();
            chk($sformatf("sticky_err_%0d", i), misalign_err, 1);
        end
        do_reset();
        chk("err_after_reset", misalign_err, 0);

        // ---------------- FPU selection and IF feedback ----------------
        drive(1'b0, 1'b0, 32'h5, 32'h0, 1'b0, 1'b0, 5'd3);
        xm_ctrl.mw.fpu_to_wb = 1'b1;
        xm_ctrl.m.branch     = 1'b1;
        xm_data.fpu_addr     = 32'h3F80_0000;
        xm_data.alu_zero     = 1'b1;
        xm_data.pc_branch    = 32'h24;
        pc_jmp               = 32'h100;
        #4;
        chk("fwd_fpu",      fwd_val,           32'h3F80_0000);
        chk("if_branch",    if_ctrl.branch,    1);
        chk("if_alu_zero",  if_ctrl.alu_zero,  1);
        chk("if_pc_branch", if_ctrl.pc_branch, 32'h24);
        chk("if_pc_jmp",    if_ctrl.pc_jmp,    32'h100);
        chk("if_jmp",       if_ctrl.jmp,       0);
        chk("if_stall",     if_ctrl.stall,     0);
        step();
        chk("wb_alu_fpu",   wb_out.alu,        32'h3F80_0000);
        xm_ctrl.m.jmp = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        #4;
        chk("if_jmp_ungated", if_ctrl.jmp, 1);
        step();

        // store through the FPU path, read it back through the ALU path
        drive(1'b0, 1'b1, 32'h10, 32'h1111, 1'b0, 1'b0, 5'd0);
        xm_ctrl.m.fpu_to_mem = 1'b1;
        xm_data.fpu_addr     = 32'hC;
        xm_data.fpu_val      = 32'hCAFE_F00D;
        step();
        drive(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 5'd1);
        step();
        chk("fpu_store_data", wb_out.mem, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 5'd1);
        step();
        chk("alu_addr_unwritten", wb_out.mem, 32'h0);

        // ---------------- randomized against reference model ----------------
        do_reset();
        pc_jmp = '0;
        for (int n = 0; n < 400; n++) begin
            int op;
            Register a0, a1;
            op = int'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 31) * 4) | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0)
                 | ($urandom_range(0, 1) << 20);
            a1 = ($urandom_range(0, 31) * 4) | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
            xm_ctrl             = '0;
            xm_ctrl.m.read_mem  = (op == 1 || op == 3);
            xm_ctrl.m.write_mem = (op == 2);
            xm_ctrl.m.fpu_to_mem = 1'($urandom_range(0, 1));
            xm_ctrl.m.branch    = 1'($urandom_range(0, 1));
            xm_ctrl.m.jmp       = 1'($urandom_range(0, 1));
            xm_ctrl.mw          = MW_ctrl'($urandom_range(0, 15));
            xm_data.alu_addr    = a0;
            xm_data.fpu_addr    = a1;
            xm_data.alu_val     = $urandom;
            xm_data.fpu_val     = $urandom;
            xm_data.dst         = RegIdx'($urandom_range(0, 31));
            xm_data.alu_zero    = 1'($urandom_range(0, 1));
            xm_data.pc_branch   = $urandom;
            pc_jmp              = $urandom;
            stall               = ($urandom_range(0, 7) == 0);
            flush               = ($urandom_range(0, 7) == 0);
            #4;
            chk("rnd_fwd", fwd_val, xm_ctrl.mw.fpu_to_wb ? a1 : a0);
            chk("rnd_if",  if_ctrl, {xm_ctrl.m.branch, xm_data.alu_zero, xm_ctrl.m.jmp,
                                     xm_data.pc_branch, pc_jmp, 1'b0});
            model_edge();
            step();
            chk("rnd_mw_ctrl", mw_ctrl,      ref_mwc);
            chk("rnd_wb_out",  wb_out,       ref_wb);
            chk("rnd_err",     misalign_err, ref_err);
            chk("rnd_ld",      ld_count,     ref_ld);
            chk("rnd_st",      st_count,     ref_st);
        end

        // ---------------- counter saturation ----------------
        do_reset();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 5'd1);
        for (int i = 0; i < 32'hFFFE; i++) step();
        chk("ld_preload", ld_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) step();
        chk("ld_saturate", ld_count, 16'hFFFF);
        chk("st_idle",     st_count, 0);

        // ---------------- reset asserted mid-store ----------------
        drive(1'b0, 1'b1, 32'h8, 32'h5555_AAAA, 1'b0, 1'b0, 5'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mw_ctrl", mw_ctrl,      0);
        chk("arst_wb_out",  wb_out,       0);
        chk("arst_err",     misalign_err, 0);
        chk("arst_ld",      ld_count,     0);
        chk("arst_st",      st_count,     0);
        step();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 5'd1);
        rst_n = 1'b1;
        step();
        chk("arst_mem_cleared", wb_out.mem, 0);
        chk("arst_ld_after",    ld_count,   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
